// File: rtl/sdac_pkg.sv
// sdac_pkg: shared definitions for the sigma-delta DAC sample controller.
//   state_t   - controller states (IDLE, PREFILL, RUN, RAMPDN)
//   mid_scale - offset-binary mid-scale code (2**(bitlen-1)) for a given code width
package sdac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_RUN     = 2'd2,
        ST_RAMPDN  = 2'd3
    } state_t;

    function automatic logic [31:0] mid_scale(input int unsigned bitlen);
        return 32'd1 << (bitlen - 1);
    endfunction

endpackage

// File: rtl/sdac_fifo.sv
// sdac_fifo: synchronous show-ahead sample FIFO.
//   clk, rst  - clock, synchronous active-high reset (pointers and level cleared)
//   flush     - synchronous clear of all contents; wins over a same-cycle push
//   push, din - write din at the tail (caller guarantees not full)
//   pop       - drop the head entry (caller guarantees not empty)
//   dout      - current head entry, valid whenever empty is low
//   level     - occupancy 0..DEPTH; empty/full derived from it
module sdac_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [LW-1:0]    level,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= din;
    end

    assign dout  = mem[rd_ptr_q];
    assign level = level_q;
    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(DEPTH));

endmodule

// File: rtl/sdac_sample_ctrl.sv
// sdac_sample_ctrl: paces buffered samples into a sigma-delta DAC input.
//   clk, rst           - clock, synchronous active-high reset
//   cfg_en             - stream enable; dropping it ramps the output back to mid-scale
//   cfg_div            - sample period minus one, in clk cycles
//   s_valid/s_data     - sample input; accepted when s_ready (FIFO not full)
//   clr_uflow          - clears the sticky underflow flag
//   dac_code           - registered DAC code, mid-scale when idle
//   sample_tick        - one-cycle pulse per sample period (only while busy)
//   uflow              - sticky: a tick in RUN found the FIFO empty
//   level              - FIFO occupancy
//   busy               - controller is not IDLE
module sdac_sample_ctrl #(
    parameter int BITLEN    = 16,
    parameter int DEPTH     = 8,
    parameter int DIV_W     = 16,
    parameter int RAMP_STEP = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_en,
    input  logic [DIV_W-1:0]       cfg_div,
    input  logic                   s_valid,
    input  logic [BITLEN-1:0]      s_data,
    output logic                   s_ready,
    input  logic                   clr_uflow,
    output logic [BITLEN-1:0]      dac_code,
    output logic                   sample_tick,
    output logic                   uflow,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy
);
    import sdac_pkg::*;

    localparam int                LW       = $clog2(DEPTH) + 1;
    localparam logic [31:0]       MID_W    = mid_scale(BITLEN);
    localparam logic [BITLEN-1:0] MID      = MID_W[BITLEN-1:0];
    localparam logic [BITLEN:0]   STEP_EXT = (BITLEN + 1)'(RAMP_STEP);
    localparam logic [LW-1:0]     HALF     = LW'(DEPTH / 2);

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [BITLEN-1:0] dac_code_q, dac_code_d;
    logic              uflow_q, uflow_d;

    logic              tick;
    logic              fifo_push, fifo_pop, fifo_flush;
    logic              fifo_empty, fifo_full;
    logic [BITLEN-1:0] fifo_dout;
    logic [LW-1:0]     fifo_level;

    logic [BITLEN:0]   code_ext, ramp_dn, ramp_up;
    logic [BITLEN-1:0] ramp_code;

    sdac_fifo #(
        .WIDTH (BITLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (fifo_flush),
        .push  (fifo_push),
        .din   (s_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .level (fifo_level),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign tick      = (state_q != ST_IDLE) && (cnt_q == cfg_div);
    assign s_ready   = !fifo_full;
    assign fifo_push = s_valid && s_ready;

    // One ramp step toward mid-scale with one guard bit: a borrow or carry
    // out of the code range, or a step past mid-scale, lands exactly on MID.
    always_comb begin
        code_ext  = {1'b0, dac_code_q};
        ramp_dn   = code_ext - STEP_EXT;
        ramp_up   = code_ext + STEP_EXT;
        ramp_code = MID;
        if (dac_code_q > MID) begin
            if (!ramp_dn[BITLEN] && (ramp_dn[BITLEN-1:0] > MID)) ramp_code = ramp_dn[BITLEN-1:0];
        end else if (dac_code_q < MID) begin
            if (!ramp_up[BITLEN] && (ramp_up[BITLEN-1:0] < MID)) ramp_code = ramp_up[BITLEN-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dac_code_d = dac_code_q;
        uflow_d    = clr_uflow ? 1'b0 : uflow_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        if (state_q == ST_IDLE) cnt_d = '0;
        else                    cnt_d = tick ? '0 : cnt_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                dac_code_d = MID;
                if (cfg_en) state_d = ST_PREFILL;
            end
            ST_PREFILL: begin
                dac_code_d = MID;
                if (!cfg_en)                  state_d = ST_IDLE;
                else if (fifo_level >= HALF)  state_d = ST_RUN;
            end
            ST_RUN: begin
                if (tick) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        dac_code_d = fifo_dout;
                    end else begin
                        // A new underflow outranks a simultaneous clear.
                        uflow_d = 1'b1;
                    end
                end
                if (!cfg_en) state_d = ST_RAMPDN;
            end
            ST_RAMPDN: begin
                // cfg_en is deliberately not looked at here.
                if (tick) dac_code_d = ramp_code;
                if (dac_code_q == MID) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Any return to IDLE discards buffered samples and restarts the period.
        if ((state_d == ST_IDLE) && (state_q != ST_IDLE)) begin
            fifo_flush = 1'b1;
            cnt_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dac_code_q <= MID;
            uflow_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dac_code_q <= dac_code_d;
            uflow_q    <= uflow_d;
        end
    end

    assign dac_code    = dac_code_q;
    assign sample_tick = tick;
    assign uflow       = uflow_q;
    assign level       = fifo_level;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sdac_sample_ctrl.sv
// Testbench for sdac_sample_ctrl: directed stimulus, a queue-based behavioural
// model compared every cycle, and literal expectations at key points.
module tb_sdac_sample_ctrl;

    localparam int BITLEN    = 16;
    localparam int DEPTH     = 8;
    localparam int DIV_W     = 16;
    localparam int RAMP_STEP = 256;
    localparam int MID       = 'h8000;

    localparam int M_IDLE = 0;
    localparam int M_PRE  = 1;
    localparam int M_RUN  = 2;
    localparam int M_RDN  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_en;
    logic [DIV_W-1:0]  cfg_div;
    logic              s_valid;
    logic [BITLEN-1:0] s_data;
    logic              s_ready;
    logic              clr_uflow;
    logic [BITLEN-1:0] dac_code;
    logic              sample_tick;
    logic              uflow;
    logic [3:0]        level;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    sdac_sample_ctrl #(
        .BITLEN    (BITLEN),
        .DEPTH     (DEPTH),
        .DIV_W     (DIV_W),
        .RAMP_STEP (RAMP_STEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_en      (cfg_en),
        .cfg_div     (cfg_div),
        .s_valid     (s_valid),
        .s_data      (s_data),
        .s_ready     (s_ready),
        .clr_uflow   (clr_uflow),
        .dac_code    (dac_code),
        .sample_tick (sample_tick),
        .uflow       (uflow),
        .level       (level),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_mode;
    int m_code;
    int m_uflow;
    int m_ph;      // cycles spent busy since leaving IDLE
    int m_q[$];
    bit m_valid = 1'b0;

    function automatic int m_tick_now();
        int d;
        d = int'(cfg_div);
        return ((m_mode != M_IDLE) && ((m_ph % (d + 1)) == d)) ? 1 : 0;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        int tk, nxt, set;
        bit psh;
        if (rst) begin
            m_mode  = M_IDLE;
            m_code  = MID;
            m_uflow = 0;
            m_ph    = 0;
            m_q.delete();
            m_valid = 1'b1;
        end else if (m_valid) begin
            tk  = m_tick_now();
            psh = s_valid && (m_q.size() != DEPTH);
            nxt = m_mode;
            set = 0;
            case (m_mode)
                M_IDLE: if (cfg_en) nxt = M_PRE;
                M_PRE: begin
                    if (!cfg_en) nxt = M_IDLE;
                    else if (m_q.size() >= DEPTH / 2) nxt = M_RUN;
                end
                M_RUN: begin
                    if (tk != 0) begin
                        if (m_q.size() > 0) m_code = m_q.pop_front();
                        else set = 1;
                    end
                    if (!cfg_en) nxt = M_RDN;
                end
                default: begin
                    if (m_code == MID) nxt = M_IDLE;
                    else if (tk != 0) begin
                        if (m_code > MID) m_code = (m_code - RAMP_STEP < MID) ? MID : m_code - RAMP_STEP;
                        else              m_code = (m_code + RAMP_STEP > MID) ? MID : m_code + RAMP_STEP;
                    end
                end
            endcase
            if (set != 0)       m_uflow = 1;
            else if (clr_uflow) m_uflow = 0;
            if (nxt == M_IDLE && m_mode != M_IDLE) m_q.delete();
            else if (psh) m_q.push_back(int'(s_data));
            m_ph   = (m_mode != M_IDLE && nxt != M_IDLE) ? m_ph + 1 : 0;
            m_mode = nxt;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            cmp("dac_code",    int'(dac_code),    m_code);
            cmp("level",       int'(level),       m_q.size());
            cmp("busy",        int'(busy),        (m_mode != M_IDLE) ? 1 : 0);
            cmp("uflow",       int'(uflow),       m_uflow);
            cmp("s_ready",     int'(s_ready),     (m_q.size() != DEPTH) ? 1 : 0);
            cmp("sample_tick", int'(sample_tick), m_tick_now());
        end
    end

    // ---------------- helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_change(input int prev, input int budget, output int val, output int n);
        n   = 0;
        val = prev;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (int'(dac_code) != prev) begin
                val = int'(dac_code);
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL dac_change_timeout: actual=%0h required=change within %0d cycles", prev, budget);
        n = -1;
    endtask

    // sel: 0 = uflow, 1 = sample_tick, 2 = level
    task automatic wait_for(input int sel, input int target, input int budget, input string name);
        int n;
        bit hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk);
            n++;
            case (sel)
                0:       hit = (int'(uflow) == target);
                1:       hit = (int'(sample_tick) == target);
                default: hit = (int'(level) == target);
            endcase
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("FAIL %s: actual=not seen required=%0h within %0d cycles", name, target, budget);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int val, n, prev;
        rst = 1'b1; cfg_en = 1'b0; cfg_div = 16'd3;
        s_valid = 1'b0; s_data = '0; clr_uflow = 1'b0;
        step(3);
        rst = 1'b0;
        @(negedge clk);
        cmp("rst_dac",   int'(dac_code), 'h8000);
        cmp("rst_level", int'(level), 0);
        cmp("rst_busy",  int'(busy), 0);
        cmp("rst_uflow", int'(uflow), 0);
        cmp("rst_ready", int'(s_ready), 1);

        // Four samples then enable: played in order, one tick per 4 cycles.
        for (int i = 0; i < 4; i++) begin
            step(1);
            s_valid = 1'b1;
            s_data  = 16'(32'hA001 + i);
        end
        step(1);
        s_valid = 1'b0;
        cfg_en  = 1'b1;
        @(negedge clk);
        cmp("prefill_level", int'(level), 4);
        prev = 'h8000;
        for (int k = 0; k < 4; k++) begin
            wait_change(prev, 30, val, n);
            cmp("run_sample", val, 'hA001 + k);
            if (k > 0) cmp("tick_spacing", n, 4);
            prev = val;
        end

        // Drained FIFO: code held, sticky underflow, clear, clear-vs-set.
        wait_for(0, 1, 20, "uflow_set");
        cmp("uflow_hold_dac", int'(dac_code), 'hA004);
        cmp("uflow_flag",     int'(uflow), 1);
        step(1);
        clr_uflow = 1'b1;
        step(1);
        clr_uflow = 1'b0;
        @(negedge clk);
        cmp("uflow_cleared", int'(uflow), 0);
        step(1);
        clr_uflow = 1'b1;
        wait_for(1, 1, 10, "tick_during_clr");
        step(1);
        clr_uflow = 1'b0;
        @(negedge clk);
        cmp("uflow_set_beats_clr", int'(uflow), 1);

        // Ramp 0x8300 -> 0x8200 -> 0x8100 -> 0x8000, then IDLE with flush.
        step(1);
        s_valid = 1'b1;
        s_data  = 16'h8300;
        step(1);
        s_valid = 1'b0;
        wait_change('hA004, 20, val, n);
        cmp("ramp_start", val, 'h8300);
        step(1);
        cfg_en  = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h1111;
        step(1);
        s_data  = 16'h2222;
        step(1);
        s_valid = 1'b0;
        @(negedge clk);
        cmp("ramp_level_kept", int'(level), 2);
        prev = 'h8300;
        for (int k = 0; k < 3; k++) begin
            wait_change(prev, 20, val, n);
            cmp("ramp_step", val, 'h8200 - k * 'h100);
            prev = val;
        end
        step(1);
        @(negedge clk);
        cmp("ramp_idle_busy",  int'(busy), 0);
        cmp("ramp_idle_level", int'(level), 0);

        // 0x80F0 ramps straight to 0x8000 with no overshoot.
        step(1);
        cfg_en  = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'h80F0;
        step(1); s_data = 16'h5555;
        step(1); s_data = 16'h5556;
        step(1); s_data = 16'h5557;
        step(1); s_valid = 1'b0;
        wait_change('h8000, 40, val, n);
        cmp("sat_start", val, 'h80F0);
        step(1);
        cfg_en = 1'b0;
        wait_change('h80F0, 20, val, n);
        cmp("sat_exact_mid", val, 'h8000);
        step(1);
        @(negedge clk);
        cmp("sat_idle_busy",  int'(busy), 0);
        cmp("sat_idle_level", int'(level), 0);

        // Full FIFO back-pressure, then push+pop at level 7.
        step(1);
        s_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_data = 16'(32'h3000 + i);
            step(1);
        end
        @(negedge clk);
        cmp("full_ready", int'(s_ready), 0);
        cmp("full_level", int'(level), 8);
        step(1);
        s_valid = 1'b0;
        cfg_en  = 1'b1;
        wait_for(2, 7, 40, "first_pop");
        step(3);
        s_valid = 1'b1;
        s_data  = 16'h3100;
        @(negedge clk);
        cmp("pushpop_tick", int'(sample_tick), 1);
        step(1);
        s_valid = 1'b0;
        @(negedge clk);
        cmp("pushpop_level", int'(level), 7);
        cmp("pushpop_dac",   int'(dac_code), 'h3001);

        // Reset mid-RUN with a simultaneous push.
        step(1);
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'hBEEF;
        cfg_en  = 1'b0;
        step(1);
        rst     = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        cmp("midrun_rst_dac",   int'(dac_code), 'h8000);
        cmp("midrun_rst_busy",  int'(busy), 0);
        cmp("midrun_rst_level", int'(level), 0);

        // cfg_div = 0: tick every cycle; ramp up from below mid-scale.
        cfg_div = 16'd0;
        step(1);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(32'h1000 + i * 'h111);
            step(1);
        end
        s_valid = 1'b0;
        cfg_en  = 1'b1;
        step(12);
        cfg_en = 1'b0;
        step(140);
        @(negedge clk);
        cmp("div0_final_busy", int'(busy), 0);
        cmp("div0_final_dac",  int'(dac_code), 'h8000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
